// File: rtl/spi_slave_ctrl.sv
// SPI slave front end for the single-port RAM: deserialises command frames,
// strobes them to the RAM and serialises read data back out on MISO.
`timescale 1ns/1ps

module spi_slave_ctrl #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);

    localparam int FRAME_LEN = ADDR_SIZE + 2;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int TXC_W     = $clog2(ADDR_SIZE);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FRAME_LEN);
    localparam logic [TXC_W-1:0] TXC_ZERO = {TXC_W{1'b0}};
    localparam logic [TXC_W-1:0] TXC_ONE  = TXC_W'(1);
    localparam logic [TXC_W-1:0] TXC_LOAD = TXC_W'(ADDR_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [CNT_W-1:0]       r_bit_cnt;
    logic [CNT_W-1:0]       w_bit_cnt_nxt;
    logic [FRAME_LEN-2:0]   r_rx_shift;
    logic [FRAME_LEN-2:0]   w_rx_shift_nxt;
    logic [FRAME_LEN-1:0]   r_rx_data;
    logic [FRAME_LEN-1:0]   w_rx_data_nxt;
    logic                   r_rx_valid;
    logic                   w_rx_valid_nxt;
    logic                   r_rd_addr_seen;
    logic                   w_rd_addr_seen_nxt;
    logic [ADDR_SIZE-1:0]   r_tx_shift;
    logic [ADDR_SIZE-1:0]   w_tx_shift_nxt;
    logic [TXC_W-1:0]       r_tx_cnt;
    logic [TXC_W-1:0]       w_tx_cnt_nxt;
    logic                   r_tx_loaded;
    logic                   w_tx_loaded_nxt;
    logic                   r_miso;
    logic                   w_miso_nxt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; the first frame bit picks write vs. which read phase
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!SS_n) begin
                    w_state_nxt = ST_CHK_CMD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CHK_CMD: begin
                if (SS_n) begin
                    w_state_nxt = ST_IDLE;
                end else if (!MOSI) begin
                    w_state_nxt = ST_WRITE;
                end else if (r_rd_addr_seen) begin
                    w_state_nxt = ST_READ_DATA;
                end else begin
                    w_state_nxt = ST_READ_ADD;
                end
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                if (SS_n) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Receive/transmit datapath next values
    always_comb begin
        w_bit_cnt_nxt      = r_bit_cnt;
        w_rx_shift_nxt     = r_rx_shift;
        w_rx_data_nxt      = r_rx_data;
        w_rx_valid_nxt     = 1'b0;
        w_rd_addr_seen_nxt = r_rd_addr_seen;
        w_tx_shift_nxt     = r_tx_shift;
        w_tx_cnt_nxt       = r_tx_cnt;
        w_tx_loaded_nxt    = r_tx_loaded;
        w_miso_nxt         = 1'b0;
        case (r_state)
            ST_CHK_CMD: begin
                if (SS_n) begin
                    w_bit_cnt_nxt   = CNT_ZERO;
                    w_tx_cnt_nxt    = TXC_ZERO;
                    w_tx_loaded_nxt = 1'b0;
                end else begin
                    w_rx_shift_nxt = {r_rx_shift[FRAME_LEN-3:0], MOSI};
                    w_bit_cnt_nxt  = CNT_ONE;
                end
            end
            ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                if (SS_n) begin
                    w_bit_cnt_nxt   = CNT_ZERO;
                    w_tx_cnt_nxt    = TXC_ZERO;
                    w_tx_loaded_nxt = 1'b0;
                end else begin
                    if (r_bit_cnt == CNT_LAST) begin
                        w_rx_data_nxt  = {r_rx_shift, MOSI};
                        w_rx_valid_nxt = 1'b1;
                        w_bit_cnt_nxt  = CNT_DONE;
                        if (r_state == ST_READ_ADD) begin
                            w_rd_addr_seen_nxt = 1'b1;
                        end else if (r_state == ST_READ_DATA) begin
                            w_rd_addr_seen_nxt = 1'b0;
                        end else begin
                            w_rd_addr_seen_nxt = r_rd_addr_seen;
                        end
                    end else if (r_bit_cnt < CNT_LAST) begin
                        w_rx_shift_nxt = {r_rx_shift[FRAME_LEN-3:0], MOSI};
                        w_bit_cnt_nxt  = r_bit_cnt + CNT_ONE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt;
                    end
                    // tx_valid is sticky in the RAM, so only trust it once our own strobe has gone
                    if ((r_state == ST_READ_DATA) && r_tx_loaded) begin
                        if (r_tx_cnt != TXC_ZERO) begin
                            w_miso_nxt     = r_tx_shift[ADDR_SIZE-1];
                            w_tx_shift_nxt = {r_tx_shift[ADDR_SIZE-2:0], 1'b0};
                            w_tx_cnt_nxt   = r_tx_cnt - TXC_ONE;
                        end else begin
                            w_miso_nxt = 1'b0;
                        end
                    end else if ((r_state == ST_READ_DATA) && (r_bit_cnt == CNT_DONE) &&
                                 !r_rx_valid && tx_valid) begin
                        w_miso_nxt      = tx_data[ADDR_SIZE-1];
                        w_tx_shift_nxt  = {tx_data[ADDR_SIZE-2:0], 1'b0};
                        w_tx_cnt_nxt    = TXC_LOAD;
                        w_tx_loaded_nxt = 1'b1;
                    end else begin
                        w_miso_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_bit_cnt_nxt   = CNT_ZERO;
                w_tx_cnt_nxt    = TXC_ZERO;
                w_tx_loaded_nxt = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt      <= CNT_ZERO;
            r_rx_shift     <= {(FRAME_LEN-1){1'b0}};
            r_rx_data      <= {FRAME_LEN{1'b0}};
            r_rx_valid     <= 1'b0;
            r_rd_addr_seen <= 1'b0;
            r_tx_shift     <= {ADDR_SIZE{1'b0}};
            r_tx_cnt       <= TXC_ZERO;
            r_tx_loaded    <= 1'b0;
            r_miso         <= 1'b0;
        end else begin
            r_bit_cnt      <= w_bit_cnt_nxt;
            r_rx_shift     <= w_rx_shift_nxt;
            r_rx_data      <= w_rx_data_nxt;
            r_rx_valid     <= w_rx_valid_nxt;
            r_rd_addr_seen <= w_rd_addr_seen_nxt;
            r_tx_shift     <= w_tx_shift_nxt;
            r_tx_cnt       <= w_tx_cnt_nxt;
            r_tx_loaded    <= w_tx_loaded_nxt;
            r_miso         <= w_miso_nxt;
        end
    end

    assign MISO     = r_miso;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule
